// File: rtl/vector_list_if.sv
// vector_list_if: host write/commit side and line-engine read side
// of the vector table, grouped for a single port.
interface vector_list_if #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int CW = 16,
  parameter int AW = 10
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [XW-1:0] wr_x0;
  logic [XW-1:0] wr_x1;
  logic [YW-1:0] wr_y0;
  logic [YW-1:0] wr_y1;
  logic [CW-1:0] wr_col;
  logic          commit;
  logic [AW:0]   commit_count;
  logic          busy;
  logic          trigger;
  logic          read_vector;
  logic [AW-1:0] vector;
  logic [XW-1:0] x0;
  logic [XW-1:0] x1;
  logic [YW-1:0] y0;
  logic [YW-1:0] y1;
  logic [CW-1:0] col;
  logic          last_vector;

  modport master (
    output wr_en, wr_addr, wr_x0, wr_x1,
    output wr_y0, wr_y1, wr_col,
    output commit, commit_count, trigger,
    output read_vector, vector,
    input  busy, x0, x1, y0, y1, col,
    input  last_vector
  );

  modport slave (
    input  wr_en, wr_addr, wr_x0, wr_x1,
    input  wr_y0, wr_y1, wr_col,
    input  commit, commit_count, trigger,
    input  read_vector, vector,
    output busy, x0, x1, y0, y1, col,
    output last_vector
  );
endinterface

// File: rtl/vector_list.sv
// vector_list: RAM-backed vector table for the line engine.
// VECTOR_LIST_DOUBLE_BUFFER_EN: two banks swapped on frame trigger.
module vector_list #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int CW = 16,
  parameter int AW = 10
) (
  input  logic         clk,
  input  logic         reset,
  vector_list_if.slave bus
);
  localparam logic [AW:0] DEPTH_C =
    {1'b1, {AW{1'b0}}};

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic [CW-1:0] col;
  } vec_t;

`ifdef VECTOR_LIST_DOUBLE_BUFFER_EN
  localparam int RAW = AW + 1;
`else
  localparam int RAW = AW;
`endif

  vec_t           mem [2**RAW];
  logic [RAW-1:0] waddr;
  logic [RAW-1:0] raddr;
  vec_t           wdata;
  logic [AW:0]    cnt_in;
  logic           lv_rd;

  logic [AW:0]    fcnt_q, fcnt_d;
  vec_t           rd_q, rd_d;
  logic           lv_q, lv_d;

  assign wdata = '{
    x0:  bus.wr_x0,
    y0:  bus.wr_y0,
    x1:  bus.wr_x1,
    y1:  bus.wr_y1,
    col: bus.wr_col
  };

  assign cnt_in =
    (bus.commit_count > DEPTH_C) ?
    DEPTH_C : bus.commit_count;

`ifdef VECTOR_LIST_DOUBLE_BUFFER_EN
  logic        front_q, front_d;
  logic        busy_q, busy_d;
  logic [AW:0] pend_q, pend_d;

  assign waddr = {~front_q, bus.wr_addr};
  assign raddr = {front_q, bus.vector};
  assign bus.busy = busy_q;

  // Commit and trigger together swap straight
  // to the new count; busy never rises.
  always_comb begin
    front_d = front_q;
    busy_d  = busy_q;
    pend_d  = pend_q;
    fcnt_d  = fcnt_q;
    if (bus.commit) begin
      pend_d = cnt_in;
      busy_d = 1'b1;
    end
    if (bus.trigger &&
        (busy_q || bus.commit)) begin
      front_d = ~front_q;
      fcnt_d  = bus.commit ? cnt_in : pend_q;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      front_q <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      front_q <= front_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
    end
  end
`else
  logic unused_trigger;

  assign unused_trigger = bus.trigger;
  assign waddr = bus.wr_addr;
  assign raddr = bus.vector;
  assign bus.busy = 1'b0;

  always_comb begin
    fcnt_d = fcnt_q;
    if (bus.commit) begin
      fcnt_d = cnt_in;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Exhausted entries read as zero so stale
  // RAM never reaches the line engine.
  assign lv_rd = ({1'b0, bus.vector} >= fcnt_q);

  always_comb begin
    rd_d = rd_q;
    lv_d = lv_q;
    if (bus.read_vector) begin
      lv_d = lv_rd;
      rd_d = lv_rd ? '0 : mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q <= '0;
      rd_q   <= '0;
      lv_q   <= 1'b1;
    end else begin
      fcnt_q <= fcnt_d;
      rd_q   <= rd_d;
      lv_q   <= lv_d;
    end
  end

  assign bus.x0          = rd_q.x0;
  assign bus.y0          = rd_q.y0;
  assign bus.x1          = rd_q.x1;
  assign bus.y1          = rd_q.y1;
  assign bus.col         = rd_q.col;
  assign bus.last_vector = lv_q;
endmodule

// File: tb/tb_vector_list.sv
// tb_vector_list: directed vectors with a scoreboard-driven
// monitor for the vector table read path and busy flag.
module tb_vector_list;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int CW = 16;
  localparam int AW = 3;

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic [CW-1:0] col;
  } vec_t;

  typedef struct {
    vec_t  d;
    bit    lv;
    bit    ckd;
    bit    bz;
    string nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic peek;
  logic seen;
  int   checks;
  int   failures;
  exp_t sb[$];

  vector_list_if #(
    .XW(XW), .YW(YW), .CW(CW), .AW(AW)
  ) bus ();

  vector_list #(
    .XW(XW), .YW(YW), .CW(CW), .AW(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input int a, input int b, input int c,
    input int d, input int e
  );
    return {10'(a), 10'(b), 10'(c),
            10'(d), 16'(e)};
  endfunction

  vec_t z, v0, v1, va, vb, vc, vd, ve;

  initial begin
    seen = 1'b0;
    forever begin
      @(posedge clk);
      seen = bus.read_vector | peek;
    end
  end

  initial begin
    exp_t e;
    vec_t act;
    forever begin
      @(negedge clk);
      if (seen) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: output with no expectation");
        end else begin
          e = sb.pop_front();
          act = {bus.x0, bus.y0, bus.x1,
                 bus.y1, bus.col};
          checks++;
          if (bus.last_vector !== e.lv) begin
            failures++;
            $display("FAIL %s lv: got %b want %b",
                     e.nm, bus.last_vector, e.lv);
          end
          checks++;
          if (bus.busy !== e.bz) begin
            failures++;
            $display("FAIL %s busy: got %b want %b",
                     e.nm, bus.busy, e.bz);
          end
          if (e.ckd) begin
            checks++;
            if (act !== e.d) begin
              failures++;
              $display("FAIL %s data: got %h want %h",
                       e.nm, act, e.d);
            end
          end
        end
      end
    end
  end

  task automatic clr();
    bus.wr_en = 1'b0;
    bus.commit = 1'b0;
    bus.trigger = 1'b0;
    bus.read_vector = 1'b0;
    peek = 1'b0;
    reset = 1'b0;
  endtask

  task automatic wr(input int a, input vec_t v);
    bus.wr_en = 1'b1;
    bus.wr_addr = AW'(a);
    {bus.wr_x0, bus.wr_y0, bus.wr_x1,
     bus.wr_y1, bus.wr_col} = v;
    @(negedge clk);
    clr();
  endtask

  task automatic cmt(input int n, input bit t);
    bus.commit = 1'b1;
    bus.commit_count = (AW + 1)'(n);
    bus.trigger = t;
    @(negedge clk);
    clr();
  endtask

  task automatic trig();
    bus.trigger = 1'b1;
    @(negedge clk);
    clr();
  endtask

  task automatic rst();
    reset = 1'b1;
    @(negedge clk);
    clr();
  endtask

  task automatic rd(
    input int i, input vec_t d, input bit lv,
    input bit ckd, input bit bz, input bit t,
    input string nm
  );
    sb.push_back('{d, lv, ckd, bz, nm});
    bus.read_vector = 1'b1;
    bus.vector = AW'(i);
    bus.trigger = t;
    @(negedge clk);
    clr();
  endtask

  task automatic pk(
    input vec_t d, input bit lv, input bit ckd,
    input bit bz, input string nm
  );
    sb.push_back('{d, lv, ckd, bz, nm});
    peek = 1'b1;
    @(negedge clk);
    clr();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    z  = '0;
    v0 = mk(0, 0, 100, 10, 'hF800);
    v1 = mk(5, 5, 6, 6, 'h07E0);
    va = mk(1, 2, 3, 4, 'h001F);
    vb = mk(10, 20, 30, 40, 'h1234);
    vc = mk(1023, 1022, 7, 9, 'hABCD);
    vd = mk(50, 60, 70, 80, 'h0F0F);
    ve = mk(300, 400, 500, 600, 'hFFFF);
    clr();
    bus.wr_addr = '0;
    {bus.wr_x0, bus.wr_y0, bus.wr_x1,
     bus.wr_y1, bus.wr_col} = '0;
    bus.commit_count = '0;
    bus.vector = '0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr();
    pk(z, 1, 1, 0, "reset_state");
    rd(0, z, 1, 1, 0, 0, "reset_read");
`ifdef VECTOR_LIST_DOUBLE_BUFFER_EN
    wr(0, v0);
    cmt(1, 0);
    rd(0, z, 1, 0, 1, 0, "pre_swap");
    trig();
    rd(0, v0, 0, 1, 0, 0, "swap_read0");
    rd(1, z, 1, 0, 0, 0, "swap_read1");
    pk(z, 1, 0, 0, "hold_lv");
    wr(0, v1);
    cmt(1, 0);
    rd(0, v0, 0, 1, 1, 0, "old_bank");
    trig();
    rd(0, v1, 0, 1, 0, 0, "new_bank");
    wr(0, va);
    wr(1, vb);
    wr(2, vc);
    cmt(3, 1);
    rd(2, vc, 0, 1, 0, 0, "cmt_trig_2");
    rd(3, z, 1, 0, 0, 0, "cmt_trig_3");
    rd(0, va, 0, 1, 0, 0, "cmt_trig_0");
    wr(0, vd);
    cmt(1, 0);
    rd(2, vc, 0, 1, 0, 1, "rd_swap_old");
    rd(2, z, 1, 0, 0, 0, "rd_swap_cnt");
    rd(0, vd, 0, 1, 0, 0, "rd_swap_new");
    wr(7, ve);
    cmt(9, 0);
    trig();
    rd(7, ve, 0, 1, 0, 0, "clamp");
    cmt(0, 0);
    trig();
    rd(0, z, 1, 0, 0, 0, "empty");
    wr(0, v0);
    cmt(2, 0);
    pk(z, 1, 0, 1, "busy_pend");
    rst();
    pk(z, 1, 1, 0, "rst_busy");
    rd(0, z, 1, 0, 0, 0, "rst_cnt");
    trig();
    rd(0, z, 1, 0, 0, 0, "no_swap");
    rd(1, z, 1, 0, 0, 0, "no_swap1");
`else
    wr(0, v0);
    cmt(1, 0);
    rd(0, v0, 0, 1, 0, 0, "sb_read0");
    rd(1, z, 1, 0, 0, 0, "sb_read1");
    trig();
    rd(0, v0, 0, 1, 0, 0, "sb_trig_ign");
    pk(v0, 0, 1, 0, "sb_hold");
    wr(1, va);
    wr(2, vb);
    cmt(3, 1);
    rd(2, vb, 0, 1, 0, 0, "sb_cnt3_2");
    rd(3, z, 1, 0, 0, 0, "sb_cnt3_3");
    wr(0, v1);
    rd(0, v1, 0, 1, 0, 0, "sb_direct");
    rd(1, va, 0, 1, 0, 0, "sb_idx1");
    wr(7, ve);
    cmt(9, 0);
    rd(7, ve, 0, 1, 0, 0, "sb_clamp");
    cmt(0, 0);
    rd(0, z, 1, 0, 0, 0, "sb_empty");
    cmt(2, 0);
    rd(1, va, 0, 1, 0, 0, "sb_cnt2");
    rst();
    pk(z, 1, 1, 0, "sb_rst");
    rd(0, z, 1, 0, 0, 0, "sb_rst_cnt");
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d left want 0",
               sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
